// File: rtl/regfile_scoreboard.sv
// Purpose : integer register file with a per-register pending-writer scoreboard.
// Latency : reads are combinational (optional same-cycle write forwarding); busy_count is registered.
// Backpressure: none; every write, issue and flush is accepted in the cycle it is presented.
//
// Ports:
//   clk, reset_n              single clock, synchronous active-low reset
//   rs1_addr/rs2_addr         read addresses; rsN_data / rsN_busy are combinational
//   wr_en/wr_addr/wr_data     writeback: commits data and retires the pending mark
//   iss_en/iss_rd             issue: marks iss_rd as having a pending writer
//   flush                     drops every pending mark (data writes still commit)
//   busy_count                registered popcount of the busy vector
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     busy_count
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     busy_cnt_nxt;

  // x0 is hardwired: a write to it is a no-op for data and scoreboard alike.
  logic wr_live;
  logic iss_live;
  assign wr_live  = wr_en && (wr_addr != '0);
  assign iss_live = iss_en && (iss_rd != '0) && !flush;

  // Next busy vector: writeback clears first so a same-cycle issue to the
  // same register wins (the new writer is still outstanding).
  always_comb begin
    busy_nxt = busy;
    if (wr_live) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_nxt = '0;
    end else if (iss_live) begin
      busy_nxt[iss_rd] = 1'b1;
    end
  end

  // The count is derived from the next vector so it lands on the same edge.
  always_comb begin
    busy_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_nxt = busy_cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_live) begin
        regs[wr_addr] <= wr_data;
      end
      busy       <= busy_nxt;
      busy_count <= busy_cnt_nxt;
    end
  end

  // Read port 1. When forwarding, the in-flight writeback both supplies the
  // data and retires the pending mark in the same cycle.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs1_busy = busy[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end else if (BYP && wr_live && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_busy = 1'b0;
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rs2_data = regs[rs2_addr];
    rs2_busy = busy[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end else if (BYP && wr_live && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic            rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
  logic            wr_en, iss_en, flush;
  logic [AW-1:0]   wr_addr, iss_rd;
  logic [XLEN-1:0] wr_data;
  logic [AW:0]     busy_count, nb_busy_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_count(busy_count)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs1_data(nb_rs1_data), .rs1_busy(nb_rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(nb_rs2_data), .rs2_busy(nb_rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_count(nb_busy_count)
  );

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    rs1_addr = 0; rs2_addr = 0; wr_addr = 0; wr_data = 0; iss_rd = 0;
    tick(); tick();
    reset_n = 1;
    rs1_addr = 5; rs2_addr = 31; #1;
    n_vec++; if (busy_count !== 0) begin n_err++; $display("FAIL reset_count got %0d want 0", busy_count); end
    n_vec++; if (rs1_data !== 0 || rs1_busy !== 0) begin n_err++; $display("FAIL reset_rs1 got %h/%b want 0/0", rs1_data, rs1_busy); end
    n_vec++; if (rs2_data !== 0 || rs2_busy !== 0) begin n_err++; $display("FAIL reset_rs2 got %h/%b want 0/0", rs2_data, rs2_busy); end
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rs1_addr = 5; #1;
    n_vec++; if (rs1_data !== 32'hDEADBEEF || rs1_busy !== 0) begin n_err++; $display("FAIL wr_rd got %h/%b want deadbeef/0", rs1_data, rs1_busy); end
    n_vec++; if (nb_rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_nb got %h want deadbeef", nb_rs1_data); end
  endtask

  task automatic test_x0();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rs1_addr = 0; #1;
    n_vec++; if (rs1_data !== 0 || rs1_busy !== 0) begin n_err++; $display("FAIL x0_same got %h/%b want 0/0", rs1_data, rs1_busy); end
    tick();
    idle(); #1;
    n_vec++; if (rs1_data !== 0 || nb_rs1_data !== 0) begin n_err++; $display("FAIL x0_next got %h/%h want 0/0", rs1_data, nb_rs1_data); end
    n_vec++; if (busy_count !== 0) begin n_err++; $display("FAIL x0_count got %0d want 0", busy_count); end
    // Issue to x0 must not mark anything.
    iss_en = 1; iss_rd = 0;
    tick();
    idle(); #1;
    n_vec++; if (busy_count !== 0 || rs1_busy !== 0) begin n_err++; $display("FAIL x0_issue got %0d/%b want 0/0", busy_count, rs1_busy); end
  endtask

  task automatic test_bypass();
    rs2_addr = 7;
    iss_en = 1; iss_rd = 7;
    tick();
    idle(); #1;
    n_vec++; if (rs2_busy !== 1 || nb_rs2_busy !== 1 || busy_count !== 1) begin n_err++; $display("FAIL byp_issue got %b/%b/%0d want 1/1/1", rs2_busy, nb_rs2_busy, busy_count); end
    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; #1;
    n_vec++; if (rs2_data !== 32'h12345678 || rs2_busy !== 0) begin n_err++; $display("FAIL byp_fwd got %h/%b want 12345678/0", rs2_data, rs2_busy); end
    n_vec++; if (nb_rs2_data !== 0 || nb_rs2_busy !== 1) begin n_err++; $display("FAIL byp_nofwd got %h/%b want 0/1", nb_rs2_data, nb_rs2_busy); end
    tick();
    idle(); #1;
    n_vec++; if (nb_rs2_data !== 32'h12345678 || nb_rs2_busy !== 0) begin n_err++; $display("FAIL byp_nb_next got %h/%b want 12345678/0", nb_rs2_data, nb_rs2_busy); end
    n_vec++; if (busy_count !== 0 || nb_busy_count !== 0) begin n_err++; $display("FAIL byp_count got %0d/%0d want 0/0", busy_count, nb_busy_count); end
  endtask

  task automatic test_issue();
    iss_en = 1; iss_rd = 3;
    tick(); #1;
    n_vec++; if (busy_count !== 1) begin n_err++; $display("FAIL iss_cnt1 got %0d want 1", busy_count); end
    iss_rd = 4;
    tick(); #1;
    n_vec++; if (busy_count !== 2) begin n_err++; $display("FAIL iss_cnt2 got %0d want 2", busy_count); end
    // Same-cycle issue and writeback to x3: new writer wins, data commits.
    iss_rd = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h0000_3333;
    tick();
    idle(); rs1_addr = 3; #1;
    n_vec++; if (busy_count !== 2 || rs1_busy !== 1) begin n_err++; $display("FAIL iss_wb_same got %0d/%b want 2/1", busy_count, rs1_busy); end
    n_vec++; if (rs1_data !== 32'h0000_3333) begin n_err++; $display("FAIL iss_wb_data got %h want 00003333", rs1_data); end
    // Re-issue to already busy x4: no double count.
    iss_en = 1; iss_rd = 4;
    tick();
    idle(); #1;
    n_vec++; if (busy_count !== 2) begin n_err++; $display("FAIL iss_dup got %0d want 2", busy_count); end
    // Writeback to non-busy x6: data lands, count unchanged.
    wr_en = 1; wr_addr = 6; wr_data = 32'h0000_0666;
    tick();
    idle(); rs2_addr = 6; #1;
    n_vec++; if (busy_count !== 2 || rs2_busy !== 0 || rs2_data !== 32'h0000_0666) begin n_err++; $display("FAIL wb_nonbusy got %0d/%b/%h want 2/0/00000666", busy_count, rs2_busy, rs2_data); end
    // Retire x3 then x4.
    wr_en = 1; wr_addr = 3; wr_data = 32'h3;
    tick(); #1;
    n_vec++; if (busy_count !== 1) begin n_err++; $display("FAIL retire3 got %0d want 1", busy_count); end
    wr_addr = 4; wr_data = 32'h4;
    tick();
    idle(); #1;
    n_vec++; if (busy_count !== 0) begin n_err++; $display("FAIL retire4 got %0d want 0", busy_count); end
  endtask

  task automatic test_flush();
    iss_en = 1;
    for (int r = 1; r <= 3; r++) begin
      iss_rd = AW'(r);
      tick();
    end
    idle(); #1;
    n_vec++; if (busy_count !== 3) begin n_err++; $display("FAIL flush_pre got %0d want 3", busy_count); end
    flush = 1; iss_en = 1; iss_rd = 9;
    wr_en = 1; wr_addr = 11; wr_data = 32'hCAFE_0011;
    tick();
    idle(); rs1_addr = 9; rs2_addr = 11; #1;
    n_vec++; if (busy_count !== 0 || rs1_busy !== 0) begin n_err++; $display("FAIL flush_clr got %0d/%b want 0/0", busy_count, rs1_busy); end
    n_vec++; if (rs2_data !== 32'hCAFE_0011) begin n_err++; $display("FAIL flush_wb got %h want cafe0011", rs2_data); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1; wr_addr = 10; wr_data = 32'hA5A5A5A5;
    tick();
    idle(); iss_en = 1; iss_rd = 10;
    tick();
    idle(); rs1_addr = 10; rs2_addr = 5; #1;
    n_vec++; if (busy_count !== 1 || rs1_busy !== 1 || rs1_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rmid_pre got %0d/%b/%h want 1/1/a5a5a5a5", busy_count, rs1_busy, rs1_data); end
    // Reset asserted with competing write/issue/flush; nothing changes until the edge.
    reset_n = 0; wr_en = 1; wr_addr = 10; wr_data = 32'h1111_2222; iss_en = 1; iss_rd = 12; #2;
    n_vec++; if (busy_count !== 1 || rs2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rmid_noedge got %0d/%h want 1/deadbeef", busy_count, rs2_data); end
    tick();
    reset_n = 1; idle(); #1;
    n_vec++; if (rs1_data !== 0 || rs1_busy !== 0 || busy_count !== 0) begin n_err++; $display("FAIL rmid_post got %h/%b/%0d want 0/0/0", rs1_data, rs1_busy, busy_count); end
    n_vec++; if (rs2_data !== 0 || nb_busy_count !== 0) begin n_err++; $display("FAIL rmid_x5 got %h/%0d want 0/0", rs2_data, nb_busy_count); end
    rs1_addr = 12; #1;
    n_vec++; if (rs1_busy !== 0) begin n_err++; $display("FAIL rmid_iss12 got %b want 0", rs1_busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_issue();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of two, >=2).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 SHALL derive localparam AW = clog2(NREG) (5 at defaults).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have ports rs1_addr / rs2_addr, input, AW, read port addresses.
REQ-008 SHALL have ports rs1_data / rs2_data, output, XLEN, read port data (combinational).
REQ-009 SHALL have ports rs1_busy / rs2_busy, output, 1, operand has pending writer (combinational).
REQ-010 SHALL have ports wr_en input 1, wr_addr input AW, wr_data input XLEN: writeback port.
REQ-011 SHALL have ports iss_en input 1, iss_rd input AW: issue port, marks iss_rd pending.
REQ-012 SHALL have port flush, input, 1, clears all pending marks.
REQ-013 SHALL have port busy_count, output, AW+1, registered count of pending registers.

Function
REQ-014 SHALL hold NREG x XLEN storage plus an NREG-bit busy vector.
REQ-015 SHALL write wr_data to entry wr_addr on the rising edge when wr_en=1 and wr_addr!=0.
REQ-016 SHALL discard writes to x0; reads of address 0 SHALL return 0 and busy 0 unconditionally.
REQ-017 SHALL read asynchronously: rsN_data = entry[rsN_addr] with no added latency.
REQ-018 With BYPASS=1, SHALL drive rsN_data = wr_data and rsN_busy = 0 when wr_en=1, wr_addr=rsN_addr, wr_addr!=0.
REQ-019 With BYPASS=0, SHALL return the pre-write entry and pre-clear busy in the write cycle; new value visible the next cycle.
REQ-020 SHALL set busy[iss_rd] on the edge when iss_en=1, iss_rd!=0, flush=0.
REQ-021 SHALL clear busy[wr_addr] on the edge when wr_en=1, unless also set by REQ-020 that cycle.
REQ-022 Simultaneous issue and writeback to the same rd: busy SHALL end 1 (new writer wins); data still written.
REQ-023 Issue to a register already busy: busy SHALL remain 1; busy_count SHALL not double-count.
REQ-024 Writeback to a non-busy register: data written, busy stays 0, busy_count unchanged.
REQ-025 flush=1 SHALL clear the entire busy vector next edge and ignore iss_en that cycle; writeback data still committed.
REQ-026 busy_count SHALL equal the popcount of the busy vector, updated on the same edge as the vector (one cycle after the causing inputs); range 0..NREG-1.
REQ-027 Addresses SHALL be full-range (no out-of-range case since NREG = 2^AW).

Reset
REQ-028 When reset_n=0 at a rising edge, all NREG entries SHALL become 0, busy vector 0, busy_count 0.
REQ-029 Reset SHALL take priority over wr_en, iss_en and flush in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard all pending marks; first post-reset cycle reads 0 from every register with busy 0.
REQ-031 Outputs SHALL not change on reset_n edges alone; effect occurs only at a clk rising edge.

Verification
REQ-032 Reset, then wr_en=1 wr_addr=5 wr_data=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF, rs1_busy=0.
REQ-033 wr_en=1 wr_addr=0 wr_data=0xFFFFFFFF -> rs1_addr=0 returns 0 same and next cycle; busy_count stays 0.
REQ-034 BYPASS=1: wr_en=1 wr_addr=7 wr_data=0x12345678 with rs2_addr=7 same cycle -> rs2_data=0x12345678, rs2_busy=0; BYPASS=0 -> old value 0.
REQ-035 iss_en rd=3, then rd=4 -> busy_count 1 then 2; same cycle iss_en rd=3 and wr_en wr_addr=3 -> busy[3] stays 1, count 2.
REQ-036 Issue rd=1,2,3 then flush=1 with iss_en rd=9 -> next cycle busy_count=0, rs1_busy(9)=0.
REQ-037 Write 0xA5A5A5A5 to x10, issue rd=10, reset_n=0 one cycle -> x10 reads 0, busy 0, busy_count 0.
